// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   EX-stage operand forwarding decode plus a load-use hazard detector
//   whose stall sequencer holds the front end for LOAD_LAT cycles
//   (legal range 1..15).
//
//   Optional statistics counters are built when the macro FWD_STATS_EN is
//   defined. They add ports fwd_exmem_cnt, fwd_memwb_cnt and stall_cnt.
//   The default build, with the macro undefined, has no counters.
module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] regRs_IDEX,
  input  logic [REG_AW-1:0] regRt_IDEX,
  input  logic [REG_AW-1:0] regRd_EXMEM,
  input  logic [REG_AW-1:0] regRd_MEMWB,
  input  logic              RegWrite_EXMEM,
  input  logic              RegWrite_MEMWB,
  input  logic              MemRead_IDEX,
  input  logic [REG_AW-1:0] regRs_IFID,
  input  logic [REG_AW-1:0] regRt_IFID,
  input  logic              UseRt_IFID,
  input  logic              flush,
  output logic [1:0]        FowardingA,
  output logic [1:0]        FowardingB,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              bubble,
  output logic              stall_busy
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]  fwd_exmem_cnt,
  output logic [CNT_W-1:0]  fwd_memwb_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Out-of-range parameters are rejected when the design is elaborated.
  if (LOAD_LAT < 1 || LOAD_LAT > 15 || CNT_W < 1) begin : g_param_check
    $error("fwd_hazard_unit: LOAD_LAT must be 1..15 and CNT_W >= 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // The first stall cycle is spent in IDLE, so STALL covers the remaining
  // LOAD_LAT-1 cycles.
  localparam logic [3:0] STALL_LEN = 4'(LOAD_LAT - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       haz;
  logic       stall;

  // EX/MEM carries the younger result, so it has priority over MEM/WB.
  // Register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] rd_exmem,
    input logic              we_exmem,
    input logic [REG_AW-1:0] rd_memwb,
    input logic              we_memwb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_exmem && (rd_exmem != '0) && (rd_exmem == src)) begin
      sel = 2'b10;
    end else if (we_memwb && (rd_memwb != '0) && (rd_memwb == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Operand-select decode. It is never gated by stall, flush or reset.
  always_comb begin
    // NOTE: combinational outputs get a default first so that no path leaves them unassigned and infers a latch.
    FowardingA = 2'b00;
    FowardingB = 2'b00;
    FowardingA = fwd_sel(regRs_IDEX, regRd_EXMEM, RegWrite_EXMEM,
                         regRd_MEMWB, RegWrite_MEMWB);
    FowardingB = fwd_sel(regRt_IDEX, regRd_EXMEM, RegWrite_EXMEM,
                         regRd_MEMWB, RegWrite_MEMWB);
  end

  // Load-use detect: the load in EX targets a register that ID reads.
  always_comb begin
    haz = MemRead_IDEX && (regRt_IDEX != '0) &&
          ((regRt_IDEX == regRs_IFID) ||
           (UseRt_IFID && (regRt_IDEX == regRt_IFID)));
  end

  // Stall outputs. An IDLE hazard stalls in the same cycle. Flush and reset
  // override everything.
  always_comb begin
    stall      = rst_n && !flush && ((state_q == STALL) || haz);
    PCWrite    = !stall;
    IFIDWrite  = !stall;
    bubble     = stall;
    stall_busy = rst_n && (state_q == STALL);
  end

  // Stall sequencer. STALL ignores new hazards until it returns to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (haz && (LOAD_LAT > 1)) begin
            state_q <= STALL;
            cnt_q   <= STALL_LEN;
          end
        end
        STALL: begin
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_exmem_cnt_q;
  logic [CNT_W-1:0] fwd_memwb_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hit_exmem;
  logic             hit_memwb;

  // Each event counts at most once per cycle, even when both operands hit.
  always_comb begin
    hit_exmem = (FowardingA == 2'b10) || (FowardingB == 2'b10);
    hit_memwb = (FowardingA == 2'b01) || (FowardingB == 2'b01);
  end

  // Saturating event counters. Each one holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_exmem_cnt_q <= '0;
      fwd_memwb_cnt_q <= '0;
      stall_cnt_q     <= '0;
    end else begin
      if (hit_exmem && (fwd_exmem_cnt_q != '1)) begin
        fwd_exmem_cnt_q <= fwd_exmem_cnt_q + CNT_W'(1);
      end
      if (hit_memwb && (fwd_memwb_cnt_q != '1)) begin
        fwd_memwb_cnt_q <= fwd_memwb_cnt_q + CNT_W'(1);
      end
      if (!PCWrite && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign fwd_exmem_cnt = fwd_exmem_cnt_q;
  assign fwd_memwb_cnt = fwd_memwb_cnt_q;
  assign stall_cnt     = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Directed vectors with hand-computed expectations. All three instances
//   share the same inputs and differ only in LOAD_LAT (1, 3 and 4). The
//   LOAD_LAT=3 instance uses CNT_W=2 so that saturation is reached quickly.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] regRs_IDEX, regRt_IDEX, regRd_EXMEM, regRd_MEMWB;
  logic       RegWrite_EXMEM, RegWrite_MEMWB, MemRead_IDEX;
  logic [4:0] regRs_IFID, regRt_IFID;
  logic       UseRt_IFID, flush;

  logic [1:0] fa1, fb1, fa3, fb3, fa4, fb4;
  logic       pc1, ifid1, bub1, busy1;
  logic       pc3, ifid3, bub3, busy3;
  logic       pc4, ifid4, bub4, busy4;
`ifdef FWD_STATS_EN
  logic [15:0] exm1, mwb1, stc1, exm4, mwb4, stc4;
  logic [1:0]  exm3, mwb3, stc3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .regRs_IDEX(regRs_IDEX), .regRt_IDEX(regRt_IDEX),
    .regRd_EXMEM(regRd_EXMEM), .regRd_MEMWB(regRd_MEMWB),
    .RegWrite_EXMEM(RegWrite_EXMEM), .RegWrite_MEMWB(RegWrite_MEMWB),
    .MemRead_IDEX(MemRead_IDEX), .regRs_IFID(regRs_IFID),
    .regRt_IFID(regRt_IFID), .UseRt_IFID(UseRt_IFID), .flush(flush),
    .FowardingA(fa1), .FowardingB(fb1), .PCWrite(pc1), .IFIDWrite(ifid1),
    .bubble(bub1), .stall_busy(busy1)
`ifdef FWD_STATS_EN
    , .fwd_exmem_cnt(exm1), .fwd_memwb_cnt(mwb1), .stall_cnt(stc1)
`endif
  );

  fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(2)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .regRs_IDEX(regRs_IDEX), .regRt_IDEX(regRt_IDEX),
    .regRd_EXMEM(regRd_EXMEM), .regRd_MEMWB(regRd_MEMWB),
    .RegWrite_EXMEM(RegWrite_EXMEM), .RegWrite_MEMWB(RegWrite_MEMWB),
    .MemRead_IDEX(MemRead_IDEX), .regRs_IFID(regRs_IFID),
    .regRt_IFID(regRt_IFID), .UseRt_IFID(UseRt_IFID), .flush(flush),
    .FowardingA(fa3), .FowardingB(fb3), .PCWrite(pc3), .IFIDWrite(ifid3),
    .bubble(bub3), .stall_busy(busy3)
`ifdef FWD_STATS_EN
    , .fwd_exmem_cnt(exm3), .fwd_memwb_cnt(mwb3), .stall_cnt(stc3)
`endif
  );

  fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(16)) u_lat4 (
    .clk(clk), .rst_n(rst_n),
    .regRs_IDEX(regRs_IDEX), .regRt_IDEX(regRt_IDEX),
    .regRd_EXMEM(regRd_EXMEM), .regRd_MEMWB(regRd_MEMWB),
    .RegWrite_EXMEM(RegWrite_EXMEM), .RegWrite_MEMWB(RegWrite_MEMWB),
    .MemRead_IDEX(MemRead_IDEX), .regRs_IFID(regRs_IFID),
    .regRt_IFID(regRt_IFID), .UseRt_IFID(UseRt_IFID), .flush(flush),
    .FowardingA(fa4), .FowardingB(fb4), .PCWrite(pc4), .IFIDWrite(ifid4),
    .bubble(bub4), .stall_busy(busy4)
`ifdef FWD_STATS_EN
    , .fwd_exmem_cnt(exm4), .fwd_memwb_cnt(mwb4), .stall_cnt(stc4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    regRs_IDEX = '0; regRt_IDEX = '0; regRd_EXMEM = '0; regRd_MEMWB = '0;
    RegWrite_EXMEM = 1'b0; RegWrite_MEMWB = 1'b0; MemRead_IDEX = 1'b0;
    regRs_IFID = '0; regRt_IFID = '0; UseRt_IFID = 1'b0; flush = 1'b0;
  endtask

  // Present a one-cycle load-use hazard on rt=8 against ID rs=8.
  task automatic set_haz();
    MemRead_IDEX = 1'b1; regRt_IDEX = 5'd8; regRs_IFID = 5'd8;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // Reset: stall outputs are forced inactive while forwarding still decodes.
    tick();
    set_haz();
    RegWrite_EXMEM = 1'b1; regRd_EXMEM = 5'd3; regRs_IDEX = 5'd3;
    #2;
    check("rst_pcwrite",   pc3,   1);
    check("rst_ifidwrite", ifid3, 1);
    check("rst_bubble",    bub3,  0);
    check("rst_busy",      busy3, 0);
    check("rst_fwdA",      fa3,   2'b10);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    #2;

    // EX/MEM has priority over MEM/WB.
    RegWrite_EXMEM = 1'b1; regRd_EXMEM = 5'd3;
    RegWrite_MEMWB = 1'b1; regRd_MEMWB = 5'd3;
    regRs_IDEX = 5'd3; regRt_IDEX = 5'd3;
    #1;
    check("prio_A", fa3, 2'b10);
    check("prio_B", fb3, 2'b10);
    RegWrite_EXMEM = 1'b0;
    #1;
    check("memwb_only_A", fa3, 2'b01);
    check("memwb_only_B", fb3, 2'b01);

    // A write to register 0 is never forwarded.
    RegWrite_EXMEM = 1'b1; regRd_EXMEM = 5'd0; regRs_IDEX = 5'd0;
    regRd_MEMWB = 5'd5; regRt_IDEX = 5'd5;
    #1;
    check("zero_reg_A", fa3, 2'b00);
    check("memwb_B",    fb3, 2'b01);
    RegWrite_EXMEM = 1'b0; regRd_EXMEM = 5'd7; regRs_IDEX = 5'd7;
    RegWrite_MEMWB = 1'b0;
    #1;
    check("nowrite_A", fa3, 2'b00);
    check("nowrite_B", fb3, 2'b00);
    RegWrite_MEMWB = 1'b1; regRd_MEMWB = 5'd6; regRt_IDEX = 5'd22;
    #1;
    check("full_width_B", fb3, 2'b00);

    // Load-use hazard: the stall lasts LOAD_LAT cycles.
    clear_inputs();
    tick();
    set_haz();
    #2;
    check("lu_c1_pc3",    pc3,   0);
    check("lu_c1_ifid3",  ifid3, 0);
    check("lu_c1_bub3",   bub3,  1);
    check("lu_c1_busy3",  busy3, 0);
    check("lu_c1_pc1",    pc1,   0);
    tick();
    MemRead_IDEX = 1'b0;
    #2;
    check("lu_c2_pc3",    pc3,   0);
    check("lu_c2_busy3",  busy3, 1);
    check("lu_c2_pc1",    pc1,   1);
    check("lu_c2_busy1",  busy1, 0);
    tick(); #2;
    check("lu_c3_pc3",    pc3,   0);
    check("lu_c3_busy3",  busy3, 1);
    check("lu_c3_pc4",    pc4,   0);
    tick(); #2;
    check("lu_c4_pc3",    pc3,   1);
    check("lu_c4_bub3",   bub3,  0);
    check("lu_c4_busy3",  busy3, 0);
    check("lu_c4_pc4",    pc4,   0);
    tick(); #2;
    check("lu_c5_pc4",    pc4,   1);
    check("lu_c5_busy4",  busy4, 0);

    // rt of the ID instruction matters only when UseRt_IFID is 1.
    MemRead_IDEX = 1'b1; regRt_IDEX = 5'd8; regRt_IFID = 5'd8;
    regRs_IFID = 5'd2; UseRt_IFID = 1'b0;
    #1;
    check("usert0_pc", pc3, 1);
    UseRt_IFID = 1'b1;
    #1;
    check("usert1_pc",  pc3, 0);
    check("usert1_bub", bub3, 1);
    regRt_IDEX = 5'd0; regRt_IFID = 5'd0; regRs_IFID = 5'd0;
    #1;
    check("ld_r0_pc", pc3, 1);
    clear_inputs();

    // A flush in stall cycle 2 releases the stall at once, and IDLE follows.
    tick();
    set_haz();
    #2;
    check("fl_c1_pc4", pc4, 0);
    tick();
    MemRead_IDEX = 1'b0; flush = 1'b1;
    #2;
    check("fl_c2_pc4",   pc4,   1);
    check("fl_c2_bub4",  bub4,  0);
    check("fl_c2_busy4", busy4, 1);
    check("fl_c2_pc3",   pc3,   1);
    tick();
    flush = 1'b0;
    #2;
    check("fl_c3_busy4", busy4, 0);
    check("fl_c3_pc4",   pc4,   1);
    check("fl_c3_busy3", busy3, 0);

    // When flush and a hazard coincide in IDLE, no stall occurs.
    set_haz(); flush = 1'b1;
    #2;
    check("flhaz_pc4",  pc4,  1);
    check("flhaz_bub4", bub4, 0);
    tick();
    clear_inputs();
    #2;
    check("flhaz_busy4", busy4, 0);

    // Reset in stall cycle 2 aborts the stall.
    tick();
    set_haz();
    #2;
    check("rs_c1_pc4", pc4, 0);
    tick();
    MemRead_IDEX = 1'b0; rst_n = 1'b0;
    #2;
    check("rs_c2_pc4",   pc4,   1);
    check("rs_c2_busy4", busy4, 0);
    tick();
    rst_n = 1'b1;
    #2;
    check("rs_c3_busy4", busy4, 0);
    check("rs_c3_pc4",   pc4,   1);

`ifdef FWD_STATS_EN
    // Statistics: the CNT_W=2 counters saturate at 3 and clear on reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    check("st_rst_exm", exm3, 0);
    RegWrite_EXMEM = 1'b1; regRd_EXMEM = 5'd3;
    regRs_IDEX = 5'd3; regRt_IDEX = 5'd3;
    tick(); tick(); #2;
    check("st_exm_2",  exm3, 2);
    tick(); tick(); tick(); #2;
    check("st_exm_sat", exm3, 3);
    check("st_mwb_0",   mwb3, 0);
    check("st_exm_w16", exm1, 5);
    clear_inputs();
    set_haz();
    tick();
    MemRead_IDEX = 1'b0;
    tick(); tick(); tick(); #2;
    check("st_stall3", stc3, 3);
    check("st_stall1", stc1, 1);
    check("st_stall4", stc4, 4);
    rst_n = 1'b0;
    tick(); #2;
    check("st_clr_exm", exm3, 0);
    check("st_clr_stc", stc3, 0);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
